uart_pio_loader: RTL and testbench

- Upstream feeder for the pio block. Replaces the hard-coded program/config sequencer in the top level.
- Receives framed command bytes from a UART receiver and validates each frame's checksum.
- Issues one action/din/index/mindex write pulse per valid frame.
- Returns an ACK/NAK byte to a UART transmitter, so programs and configuration are loaded at run time instead of from initial blocks.

---
 rtl/uart_pio_loader_pkg.sv | 21 ++
 rtl/loader_timeout.sv | 29 ++
 rtl/uart_pio_loader.sv | 121 ++++++++++++
 tb/tb_uart_pio_loader.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pio_loader_pkg.sv
// rtl/uart_pio_loader_pkg.sv - shared types and constants for the UART pio loader
package uart_pio_loader_pkg;

    typedef enum logic [1:0] {
        RECV  = 2'd0,
        CHECK = 2'd1,
        ISSUE = 2'd2,
        REPLY = 2'd3
    } state_t;

    localparam int FRAME_LEN = 7;

    localparam int B0_ACTION_MSB = 7;
    localparam int B0_ACTION_LSB = 4;
    localparam int B0_MINDEX_MSB = 3;
    localparam int B0_MINDEX_LSB = 2;

    localparam logic [7:0] DEFAULT_ACK = 8'h06;
    localparam logic [7:0] DEFAULT_NAK = 8'h15;

endpackage

// File: rtl/loader_timeout.sv
// rtl/loader_timeout.sv - inter-byte idle counter with clear/enable and expire flag
module loader_timeout #(
    parameter int TIMEOUT_CYCLES = 250000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int W = $clog2(TIMEOUT_CYCLES);
    localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);

    logic [W-1:0] cnt;

    assign expire = enable && (cnt == LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable && (cnt != LAST)) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_pio_loader.sv
// rtl/uart_pio_loader.sv - checksummed UART frame parser issuing pio write pulses with ACK/NAK
module uart_pio_loader
    import uart_pio_loader_pkg::*;
#(
    parameter int         TIMEOUT_CYCLES = 250000,
    parameter logic [7:0] ACK_BYTE       = DEFAULT_ACK,
    parameter logic [7:0] NAK_BYTE       = DEFAULT_NAK
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic [3:0]  action,
    output logic [31:0] din,
    output logic [4:0]  index,
    output logic [1:0]  mindex,
    output logic [7:0]  cmd_count,
    output logic        err_timeout,
    output logic        err_overrun
);

    state_t     state;
    logic [2:0] byte_cnt;
    logic [7:0] frame [FRAME_LEN];
    logic [7:0] csum;
    logic [3:0] frame_action;
    logic       tmr_clear;
    logic       tmr_expire;

    always_comb begin
        csum = '0;
        for (int i = 0; i < FRAME_LEN; i++) begin
            csum = csum ^ frame[i];
        end
    end

    assign frame_action = frame[0][B0_ACTION_MSB:B0_ACTION_LSB];

    // Idle time only counts while a partial frame is pending.
    assign tmr_clear = (state != RECV) || (byte_cnt == 3'd0) || rx_valid;

    loader_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (clk),
        .reset  (reset),
        .clear  (tmr_clear),
        .enable (!tmr_clear),
        .expire (tmr_expire)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= RECV;
            byte_cnt    <= '0;
            tx_data     <= '0;
            tx_valid    <= 1'b0;
            action      <= '0;
            din         <= '0;
            index       <= '0;
            mindex      <= '0;
            cmd_count   <= '0;
            err_timeout <= 1'b0;
            err_overrun <= 1'b0;
            for (int i = 0; i < FRAME_LEN; i++) begin
                frame[i] <= '0;
            end
        end else begin
            action <= '0;
            case (state)
                RECV: begin
                    if (rx_valid) begin
                        frame[byte_cnt] <= rx_data;
                        byte_cnt        <= byte_cnt + 3'd1;
                        if (byte_cnt == 3'(FRAME_LEN - 1)) begin
                            state <= CHECK;
                        end
                    end else if (tmr_expire) begin
                        byte_cnt    <= '0;
                        err_timeout <= 1'b1;
                    end
                end
                CHECK: begin
                    if ((csum == 8'h00) && (frame_action != 4'd0)) begin
                        state     <= ISSUE;
                        action    <= frame_action;
                        din       <= {frame[5], frame[4], frame[3], frame[2]};
                        index     <= frame[1][4:0];
                        mindex    <= frame[0][B0_MINDEX_MSB:B0_MINDEX_LSB];
                        cmd_count <= cmd_count + 8'd1;
                    end else begin
                        state    <= REPLY;
                        tx_valid <= 1'b1;
                        tx_data  <= (csum == 8'h00) ? ACK_BYTE : NAK_BYTE;
                    end
                end
                ISSUE: begin
                    state    <= REPLY;
                    tx_valid <= 1'b1;
                    tx_data  <= ACK_BYTE;
                end
                REPLY: begin
                    if (tx_ready) begin
                        tx_valid <= 1'b0;
                        byte_cnt <= '0;
                        state    <= RECV;
                    end
                end
                default: state <= RECV;
            endcase
            // Bytes arriving outside RECV are dropped, never stored.
            if (rx_valid && (state != RECV)) begin
                err_overrun <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_uart_pio_loader.sv
// tb/tb_uart_pio_loader.sv - directed self-checking bench for uart_pio_loader
module tb_uart_pio_loader;

    logic        clk;
    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [3:0]  action;
    logic [31:0] din;
    logic [4:0]  index;
    logic [1:0]  mindex;
    logic [7:0]  cmd_count;
    logic        err_timeout;
    logic        err_overrun;

    int checks   = 0;
    int failures = 0;

    int         pulse_cnt   = 0;
    logic [3:0] last_action = '0;
    int         tx_cnt      = 0;
    logic [7:0] last_tx     = '0;
    logic       prev_tx_valid = 1'b0;

    int exp_cmd   = 0;
    int exp_pulse = 0;
    int exp_tx    = 0;

    localparam logic [55:0] F_PROG  = 56'h10_00_81_E0_00_00_71;
    localparam logic [55:0] F_EN    = 56'h60_00_01_00_00_00_61;
    localparam logic [55:0] F_BAD   = 56'h10_00_81_E0_00_00_70;
    localparam logic [55:0] F_PING  = 56'h00_00_00_00_00_00_00;
    localparam logic [55:0] F_FIELD = 56'h39_F5_78_56_34_12_C4;

    uart_pio_loader #(
        .TIMEOUT_CYCLES(100)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .action      (action),
        .din         (din),
        .index       (index),
        .mindex      (mindex),
        .cmd_count   (cmd_count),
        .err_timeout (err_timeout),
        .err_overrun (err_overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (action != 4'd0) begin
            pulse_cnt   <= pulse_cnt + 1;
            last_action <= action;
        end
        prev_tx_valid <= tx_valid;
        if (tx_valid && !prev_tx_valid) begin
            tx_cnt  <= tx_cnt + 1;
            last_tx <= tx_data;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic send_bytes(input logic [55:0] f, input int n);
        for (int i = 0; i < n; i++) send_byte(f[55-8*i -: 8]);
    endtask

    task automatic check_accepted(input string tag, input logic [3:0] act, input logic [31:0] d,
                                  input logic [4:0] idx, input logic [1:0] mi);
        exp_cmd++;
        exp_pulse++;
        exp_tx++;
        check({tag, "_pulses"}, pulse_cnt, exp_pulse);
        check({tag, "_action"}, last_action, act);
        check({tag, "_din"}, din, d);
        check({tag, "_index"}, index, idx);
        check({tag, "_mindex"}, mindex, mi);
        check({tag, "_cmd_count"}, cmd_count, exp_cmd);
        check({tag, "_replies"}, tx_cnt, exp_tx);
        check({tag, "_reply"}, last_tx, 8'h06);
    endtask

    initial begin
        reset    = 1'b1;
        rx_data  = '0;
        rx_valid = 1'b0;
        tx_ready = 1'b1;
        wait_cycles(3);
        check("rst_action", action, 0);
        check("rst_tx_valid", tx_valid, 0);
        check("rst_cmd_count", cmd_count, 0);
        check("rst_din", din, 0);
        check("rst_err", {err_timeout, err_overrun}, 0);
        reset = 1'b0;
        wait_cycles(2);

        // Program write with cycle-exact latency
        send_bytes(F_PROG, 7);
        check("lat_check_action", action, 0);
        check("lat_check_txv", tx_valid, 0);
        @(negedge clk);
        check("lat_issue_action", action, 1);
        check("lat_issue_din", din, 32'h0000E081);
        check("lat_issue_txv", tx_valid, 0);
        @(negedge clk);
        check("lat_reply_action", action, 0);
        check("lat_reply_txv", tx_valid, 1);
        check("lat_reply_data", tx_data, 8'h06);
        check("lat_reply_cmd", cmd_count, 1);
        exp_cmd = 1; exp_pulse = 1; exp_tx = 1;

        // Enable machine, back-to-back
        send_bytes(F_EN, 7);
        wait_cycles(3);
        check_accepted("enable", 4'd6, 32'h1, 5'd0, 2'd0);
        check("din_hold", din, 32'h1);

        // Bad checksum
        send_bytes(F_BAD, 7);
        wait_cycles(3);
        exp_tx++;
        check("bad_pulses", pulse_cnt, exp_pulse);
        check("bad_reply", last_tx, 8'h15);
        check("bad_replies", tx_cnt, exp_tx);
        check("bad_cmd_count", cmd_count, exp_cmd);
        send_bytes(F_PROG, 7);
        wait_cycles(3);
        check_accepted("after_bad", 4'd1, 32'h0000E081, 5'd0, 2'd0);

        // Ping
        send_bytes(F_PING, 7);
        wait_cycles(3);
        exp_tx++;
        check("ping_pulses", pulse_cnt, exp_pulse);
        check("ping_reply", last_tx, 8'h06);
        check("ping_replies", tx_cnt, exp_tx);
        check("ping_cmd_count", cmd_count, exp_cmd);

        // Field extraction, reserved bits set
        send_bytes(F_FIELD, 7);
        wait_cycles(3);
        check_accepted("fields", 4'd3, 32'h12345678, 5'd21, 2'd2);

        // Timeout on a 3-byte partial frame
        send_bytes(F_PROG, 3);
        wait_cycles(50);
        check("timeout_early", err_timeout, 0);
        wait_cycles(60);
        check("timeout_flag", err_timeout, 1);
        check("timeout_no_reply", tx_cnt, exp_tx);
        check("timeout_txv", tx_valid, 0);
        check("timeout_no_overrun", err_overrun, 0);
        send_bytes(F_EN, 7);
        wait_cycles(3);
        check_accepted("after_timeout", 4'd6, 32'h1, 5'd0, 2'd0);

        // Backpressure with an overrun byte during the hold
        tx_ready = 1'b0;
        send_bytes(F_PROG, 7);
        wait_cycles(2);
        for (int i = 0; i < 20; i++) begin
            check("hold_txv", tx_valid, 1);
            check("hold_data", tx_data, 8'h06);
            if (i == 5) begin
                rx_data  = 8'hAA;
                rx_valid = 1'b1;
            end else begin
                rx_valid = 1'b0;
            end
            @(negedge clk);
        end
        rx_valid = 1'b0;
        check("overrun_flag", err_overrun, 1);
        tx_ready = 1'b1;
        wait_cycles(2);
        check("hold_release_txv", tx_valid, 0);
        check_accepted("hold", 4'd1, 32'h0000E081, 5'd0, 2'd0);
        send_bytes(F_EN, 7);
        wait_cycles(3);
        check_accepted("after_overrun", 4'd6, 32'h1, 5'd0, 2'd0);

        // Reset mid-frame
        send_bytes(F_FIELD, 3);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("midrst_action", action, 0);
        check("midrst_din", din, 0);
        check("midrst_idx", {index, mindex}, 0);
        check("midrst_cmd", cmd_count, 0);
        check("midrst_err", {err_timeout, err_overrun}, 0);
        check("midrst_tx", {tx_valid, tx_data}, 0);
        wait_cycles(2);
        reset = 1'b0;
        exp_cmd = 0;
        send_bytes(F_PROG, 7);
        wait_cycles(3);
        check_accepted("after_reset", 4'd1, 32'h0000E081, 5'd0, 2'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
